// File: rtl/lenet_layer_sched_pkg.sv
// Shared types and constants for the LeNet run sequencer.
// Holds the state encoding, layer indices and debug-word field positions.
package lenet_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LAYER = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [2:0] L_CONV1 = 3'd0;
    localparam logic [2:0] L_CONV2 = 3'd1;
    localparam logic [2:0] L_CONV3 = 3'd2;
    localparam logic [2:0] L_FC1   = 3'd3;
    localparam logic [2:0] L_FC2   = 3'd4;
    localparam int         NUM_LAYERS = 5;

    localparam int DBG_ERR_BIT   = 31;
    localparam int DBG_STATE_LSB = 28;
    localparam int DBG_LAYER_LSB = 25;
    localparam int DBG_CNT_W     = 25;

endpackage

// File: rtl/lenet_layer_sched_if.sv
// Host config, DMA and layer-engine handshake bundle around the run sequencer.
// The master side is the sequencer; the slave side is the host plus engines.
interface lenet_layer_sched_if;

    logic        conf_done;
    logic [31:0] conf_info_scale_CONV1;
    logic [31:0] conf_info_scale_CONV2;
    logic [31:0] conf_info_scale_CONV3;
    logic [31:0] conf_info_scale_FC1;
    logic [31:0] conf_info_scale_FC2;
    logic        read_start;
    logic        read_done;
    logic        layer_start;
    logic [2:0]  layer_id;
    logic [31:0] layer_scale;
    logic        layer_done;
    logic        write_start;
    logic        write_done;
    logic        acc_done;
    logic        busy;
    logic [31:0] debug;

    modport master (
        input  conf_done, conf_info_scale_CONV1, conf_info_scale_CONV2,
               conf_info_scale_CONV3, conf_info_scale_FC1, conf_info_scale_FC2,
               read_done, layer_done, write_done,
        output read_start, layer_start, layer_id, layer_scale, write_start,
               acc_done, busy, debug
    );

    modport slave (
        output conf_done, conf_info_scale_CONV1, conf_info_scale_CONV2,
               conf_info_scale_CONV3, conf_info_scale_FC1, conf_info_scale_FC2,
               read_done, layer_done, write_done,
        input  read_start, layer_start, layer_id, layer_scale, write_start,
               acc_done, busy, debug
    );

endinterface

// File: rtl/lenet_layer_sched_watchdog.sv
// Per-phase watchdog: cleared on phase entry, saturates at all-ones.
// expired is a decode of the registered count, so it has no input path.
module sched_watchdog #(
    parameter int TIMEOUT_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    assign expired = &cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/lenet_layer_sched.sv
// Run sequencer: DMA load, five compute layers, DMA store, then acc_done.
// Every output is a register or a decode of registered state only.
module lenet_layer_sched
    import lenet_sched_pkg::*;
#(
    parameter int TIMEOUT_W = 20
) (
    input logic                 clk,
    input logic                 rst,
    lenet_layer_sched_if.master bus
);

    state_e                 state_q, state_d;
    logic                   read_start_q, read_start_d;
    logic                   layer_start_q, layer_start_d;
    logic                   write_start_q, write_start_d;
    logic [2:0]             layer_id_q, layer_id_d, nxt_id;
    logic [31:0]            layer_scale_q, layer_scale_d;
    logic                   err_q, err_d;
    logic [DBG_CNT_W-1:0]   run_cnt_q, run_cnt_d;
    logic [31:0]            scale_q [NUM_LAYERS];
    logic [31:0]            scale_d [NUM_LAYERS];
    logic                   wd_clr, wd_en, wd_expired;

    sched_watchdog #(.TIMEOUT_W(TIMEOUT_W)) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // A done is only honoured once its start pulse has dropped; a done wins over expiry.
    always_comb begin
        state_d       = state_q;
        read_start_d  = 1'b0;
        layer_start_d = 1'b0;
        write_start_d = 1'b0;
        layer_id_d    = layer_id_q;
        layer_scale_d = layer_scale_q;
        err_d         = err_q;
        scale_d       = scale_q;
        nxt_id        = layer_id_q + 3'd1;
        run_cnt_d     = run_cnt_q;
        if (state_q != S_IDLE && run_cnt_q != '1) begin
            run_cnt_d = run_cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.conf_done) begin
                    state_d          = S_READ;
                    read_start_d     = 1'b1;
                    scale_d[L_CONV1] = bus.conf_info_scale_CONV1;
                    scale_d[L_CONV2] = bus.conf_info_scale_CONV2;
                    scale_d[L_CONV3] = bus.conf_info_scale_CONV3;
                    scale_d[L_FC1]   = bus.conf_info_scale_FC1;
                    scale_d[L_FC2]   = bus.conf_info_scale_FC2;
                    layer_id_d       = L_CONV1;
                    layer_scale_d    = bus.conf_info_scale_CONV1;
                    err_d            = 1'b0;
                    run_cnt_d        = '0;
                end
            end
            S_READ: begin
                if (bus.read_done && !read_start_q) begin
                    state_d       = S_LAYER;
                    layer_start_d = 1'b1;
                    layer_id_d    = L_CONV1;
                    layer_scale_d = scale_q[L_CONV1];
                end else if (wd_expired) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_LAYER: begin
                if (bus.layer_done && !layer_start_q) begin
                    if (layer_id_q == L_FC2) begin
                        state_d       = S_WRITE;
                        write_start_d = 1'b1;
                    end else begin
                        layer_start_d = 1'b1;
                        layer_id_d    = nxt_id;
                        layer_scale_d = scale_q[nxt_id];
                    end
                end else if (wd_expired) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_WRITE: begin
                if (bus.write_done && !write_start_q) begin
                    state_d = S_DONE;
                end else if (wd_expired) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        wd_clr = read_start_d | layer_start_d | write_start_d;
        wd_en  = (state_q == S_READ) || (state_q == S_LAYER) || (state_q == S_WRITE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            read_start_q  <= 1'b0;
            layer_start_q <= 1'b0;
            write_start_q <= 1'b0;
            layer_id_q    <= '0;
            layer_scale_q <= '0;
            err_q         <= 1'b0;
            run_cnt_q     <= '0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                scale_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            read_start_q  <= read_start_d;
            layer_start_q <= layer_start_d;
            write_start_q <= write_start_d;
            layer_id_q    <= layer_id_d;
            layer_scale_q <= layer_scale_d;
            err_q         <= err_d;
            run_cnt_q     <= run_cnt_d;
            scale_q       <= scale_d;
        end
    end

    assign bus.read_start  = read_start_q;
    assign bus.layer_start = layer_start_q;
    assign bus.write_start = write_start_q;
    assign bus.layer_id    = layer_id_q;
    assign bus.layer_scale = layer_scale_q;
    assign bus.acc_done    = (state_q == S_DONE);
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.debug       = {err_q, state_q, layer_id_q, run_cnt_q};

endmodule

// File: tb/tb_lenet_layer_sched.sv
// Directed bench for the LeNet run sequencer, built with a 4-bit watchdog.
// Inputs change 1 time unit after each rising edge; outputs are checked there too.
module tb_lenet_layer_sched;
    import lenet_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          nAsserts = 0;
    int          nFail = 0;
    int          cycleNo = 0;
    logic [31:0] expScale [5];

    lenet_layer_sched_if busIf();

    lenet_layer_sched #(.TIMEOUT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (busIf.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cycleNo++;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic conf, input logic rd, input logic ld, input logic wd);
        busIf.conf_done  = conf;
        busIf.read_done  = rd;
        busIf.layer_done = ld;
        busIf.write_done = wd;
    endtask

    task automatic setScales(input logic [31:0] s0, input logic [31:0] s1, input logic [31:0] s2,
                             input logic [31:0] s3, input logic [31:0] s4);
        busIf.conf_info_scale_CONV1 = s0;
        busIf.conf_info_scale_CONV2 = s1;
        busIf.conf_info_scale_CONV3 = s2;
        busIf.conf_info_scale_FC1   = s3;
        busIf.conf_info_scale_FC2   = s4;
        expScale[0] = s0;
        expScale[1] = s1;
        expScale[2] = s2;
        expScale[3] = s3;
        expScale[4] = s4;
    endtask

    // Called in a start cycle: wait lat cycles, then pulse the matching done for one cycle.
    task automatic finishPhase(input int lat, input int which);
        for (int i = 0; i < lat; i++) begin
            tick();
            if (i == 0) begin
                checkOutput("start_pulse_low",
                            32'({busIf.read_start, busIf.layer_start, busIf.write_start}), 32'd0);
            end
        end
        applyStimulus(1'b0, which == 0, which == 1, which == 2);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic runNormal(input int lat, input bit midChange);
        int t0;
        int expLen;
        expLen = 7 * (lat + 1) + 1;
        t0 = cycleNo;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("read_start", 32'(busIf.read_start), 32'd1);
        checkOutput("busy_run", 32'(busIf.busy), 32'd1);
        checkOutput("err_clear", 32'(busIf.debug[31]), 32'd0);
        finishPhase(lat, 0);
        for (int id = 0; id < 5; id++) begin
            checkOutput("layer_start", 32'(busIf.layer_start), 32'd1);
            checkOutput("layer_id", 32'(busIf.layer_id), 32'(id));
            checkOutput("layer_scale", busIf.layer_scale, expScale[id]);
            if (midChange && id == 1) begin
                busIf.conf_info_scale_FC2 = 32'h0000_FFFF;
            end
            finishPhase(lat, 1);
        end
        checkOutput("write_start", 32'(busIf.write_start), 32'd1);
        finishPhase(lat, 2);
        checkOutput("acc_done", 32'(busIf.acc_done), 32'd1);
        checkOutput("acc_latency", 32'(cycleNo - t0), 32'(expLen));
        checkOutput("err_nominal", 32'(busIf.debug[31]), 32'd0);
        tick();
        checkOutput("acc_done_1cyc", 32'(busIf.acc_done), 32'd0);
        checkOutput("busy_drop", 32'(busIf.busy), 32'd0);
        checkOutput("run_count", 32'(busIf.debug[24:0]), 32'(expLen));
    endtask

    initial begin
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        setScales(32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        #1 rst = 1'b0;
        #1;
        checkOutput("rst_busy", 32'(busIf.busy), 32'd0);
        checkOutput("rst_acc_done", 32'(busIf.acc_done), 32'd0);
        checkOutput("rst_starts", 32'({busIf.read_start, busIf.layer_start, busIf.write_start}), 32'd0);
        checkOutput("rst_layer_id", 32'(busIf.layer_id), 32'd0);
        checkOutput("rst_layer_scale", busIf.layer_scale, 32'd0);
        checkOutput("rst_debug", busIf.debug, 32'd0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        $display("[TB] nominal run with mid-run scale change");
        runNormal(3, 1'b1);
        checkOutput("err_after_nominal", 32'(busIf.debug[31]), 32'd0);

        $display("[TB] stray and blocked events");
        setScales(32'd10, 32'd20, 32'd30, 32'd40, 32'd50);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("stray_idle_busy", 32'(busIf.busy), 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("held_read_start", 32'(busIf.read_start), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        checkOutput("stray_read_state", 32'(busIf.debug[30:28]), 32'(S_READ));
        checkOutput("held_read_ignored", 32'(busIf.layer_start), 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("held_read_accepted", 32'(busIf.layer_start), 32'd1);
        checkOutput("held_layer_state", 32'(busIf.debug[30:28]), 32'(S_LAYER));
        checkOutput("held_layer_scale", busIf.layer_scale, 32'd10);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("conf_in_layer_rs", 32'(busIf.read_start), 32'd0);
        checkOutput("conf_in_layer_state", 32'(busIf.debug[30:28]), 32'(S_LAYER));
        checkOutput("conf_in_layer_count", 32'(busIf.debug[24:0]), 32'd4);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int id = 1; id < 5; id++) begin
            checkOutput("stray_layer_id", 32'(busIf.layer_id), 32'(id));
            checkOutput("stray_layer_scale", busIf.layer_scale, expScale[id]);
            finishPhase(1, 1);
        end
        finishPhase(1, 2);
        checkOutput("stray_acc_done", 32'(busIf.acc_done), 32'd1);
        tick();

        $display("[TB] watchdog timeout");
        setScales(32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        finishPhase(1, 0);
        checkOutput("to_layer_start", 32'(busIf.layer_start), 32'd1);
        repeat (15) tick();
        checkOutput("to_not_yet", 32'(busIf.acc_done), 32'd0);
        checkOutput("to_still_layer", 32'(busIf.debug[30:28]), 32'(S_LAYER));
        tick();
        checkOutput("to_acc_done", 32'(busIf.acc_done), 32'd1);
        checkOutput("to_err_set", 32'(busIf.debug[31]), 32'd1);
        checkOutput("to_state_done", 32'(busIf.debug[30:28]), 32'(S_DONE));
        checkOutput("to_layer_field", 32'(busIf.debug[27:25]), 32'd0);
        tick();
        checkOutput("to_idle", 32'(busIf.busy), 32'd0);
        checkOutput("to_err_sticky", 32'(busIf.debug[31]), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("to_err_cleared", 32'(busIf.debug[31]), 32'd0);
        checkOutput("to_rerun_start", 32'(busIf.read_start), 32'd1);

        $display("[TB] done coincident with expiry, then reset in WRITE");
        finishPhase(1, 0);
        repeat (15) tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("tie_layer_start", 32'(busIf.layer_start), 32'd1);
        checkOutput("tie_layer_id", 32'(busIf.layer_id), 32'd1);
        checkOutput("tie_err", 32'(busIf.debug[31]), 32'd0);
        for (int id = 1; id < 5; id++) begin
            finishPhase(1, 1);
        end
        checkOutput("pre_rst_write_start", 32'(busIf.write_start), 32'd1);
        tick();
        checkOutput("pre_rst_write_state", 32'(busIf.debug[30:28]), 32'(S_WRITE));
        #2 rst = 1'b0;
        #1;
        checkOutput("arst_busy", 32'(busIf.busy), 32'd0);
        checkOutput("arst_acc_done", 32'(busIf.acc_done), 32'd0);
        checkOutput("arst_starts", 32'({busIf.read_start, busIf.layer_start, busIf.write_start}), 32'd0);
        checkOutput("arst_layer_id", 32'(busIf.layer_id), 32'd0);
        checkOutput("arst_layer_scale", busIf.layer_scale, 32'd0);
        checkOutput("arst_debug", busIf.debug, 32'd0);
        tick();
        rst = 1'b1;
        tick();
        checkOutput("post_rst_acc", 32'(busIf.acc_done), 32'd0);
        checkOutput("post_rst_starts", 32'({busIf.read_start, busIf.layer_start, busIf.write_start}), 32'd0);
        tick();
        checkOutput("post_rst_acc2", 32'(busIf.acc_done), 32'd0);
        checkOutput("post_rst_busy", 32'(busIf.busy), 32'd0);

        $display("[TB] minimum-latency run");
        setScales(32'd6, 32'd7, 32'd8, 32'd9, 32'hDEAD_BEEF);
        runNormal(1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
        $finish;
    end

endmodule
